seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_mult_pkg.sv | 24 ++
 rtl/seq_multiplier_twos_negate.sv | 19 +
 rtl/seq_multiplier.sv | 115 +++++++++++
 tb/tb_seq_multiplier.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// ============================================================================
// Module   : seq_mult_pkg
// Brief    : Shared FSM state encoding and sizing helper for seq_multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Counter must be able to represent WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_multiplier_twos_negate.sv
// ============================================================================
// Module   : twos_negate
// Brief    : Parametrised two's-complement negation (invert and add one).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twos_negate #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val
);

   assign o_val = ~i_val + W'(1);

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module   : seq_multiplier
// Brief    : Radix-2 shift-add sequential multiplier, signed or unsigned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier
   import seq_mult_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int SIGNED_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int               c_cnt_w = cnt_width(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   state_t                 r_state;
   logic [2*WIDTH:0]       r_acc;
   logic [WIDTH-1:0]       r_mcand;
   logic [c_cnt_w-1:0]     r_cnt;
   logic                   r_sign;

   logic                   w_signed;
   logic [WIDTH-1:0]       w_neg_a;
   logic [WIDTH-1:0]       w_neg_b;
   logic [WIDTH-1:0]       w_mag_a;
   logic [WIDTH-1:0]       w_mag_b;
   logic [2*WIDTH-1:0]     w_neg_p;
   logic [WIDTH:0]         w_sum;
   logic [2*WIDTH:0]       w_step;

   assign w_signed = (SIGNED_EN != 0) && signed_mode;

   twos_negate #(.W(WIDTH)) u_neg_a (
      .i_val (a),
      .o_val (w_neg_a)
   );

   twos_negate #(.W(WIDTH)) u_neg_b (
      .i_val (b),
      .o_val (w_neg_b)
   );

   twos_negate #(.W(2*WIDTH)) u_neg_p (
      .i_val (r_acc[2*WIDTH-1:0]),
      .o_val (w_neg_p)
   );

   // The most negative operand negates to itself, which read unsigned is its magnitude.
   assign w_mag_a = (w_signed && a[WIDTH-1]) ? w_neg_a : a;
   assign w_mag_b = (w_signed && b[WIDTH-1]) ? w_neg_b : b;

   // Multiplier lives in the low half of the accumulator and shifts out as partials shift in.
   assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
   assign w_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:0]} : r_acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
         r_sign  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  r_acc   <= {{(WIDTH+1){1'b0}}, w_mag_b};
                  r_mcand <= w_mag_a;
                  r_sign  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_acc <= w_step >> 1;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               product <= r_sign ? w_neg_p : r_acc[2*WIDTH-1:0];
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= DONE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// Module   : tb_seq_multiplier
// Brief    : Directed self-checking bench for seq_multiplier at WIDTH=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       signed_mode;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;

   logic       u_start;
   logic       u_signed_mode;
   logic [3:0] u_a;
   logic [3:0] u_b;
   logic       u_busy;
   logic       u_done;
   logic [7:0] u_product;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(4), .SIGNED_EN(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .product     (product)
   );

   seq_multiplier #(.WIDTH(4), .SIGNED_EN(0)) dut_u (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (u_start),
      .signed_mode (u_signed_mode),
      .a           (u_a),
      .b           (u_b),
      .busy        (u_busy),
      .done        (u_done),
      .product     (u_product)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One operation on the signed-capable instance; checks latency and product.
   task automatic run_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                         input logic sm, input logic [7:0] exp);
      int lat;
      a = va; b = vb; signed_mode = sm; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, lat, 5);
      chk({tag, "_product"}, product, exp);
      tick();
   endtask

   initial begin
      int cnt;
      int gap;
      rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
      u_start = 1'b0; u_signed_mode = 1'b0; u_a = '0; u_b = '0;
      tick();
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_product", product, 0);
      rst_n = 1'b1;
      tick();

      run_op("u15x15", 4'hF, 4'hF, 1'b0, 8'hE1);
      run_op("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
      run_op("s_m3x5", 4'hD, 4'h5, 1'b1, 8'hF1);
      run_op("s_7xm1", 4'h7, 4'hF, 1'b1, 8'hF9);
      run_op("s_m8x7", 4'h8, 4'h7, 1'b1, 8'hC8);
      run_op("s_0xm3", 4'h0, 4'hD, 1'b1, 8'h00);
      run_op("u_9x11", 4'h9, 4'hB, 1'b0, 8'h63);

      // Product must hold through IDLE.
      tick(); tick(); tick();
      chk("hold_idle_product", product, 8'h63);

      // Restart attempt and operand changes while busy.
      a = 4'd6; b = 4'd7; signed_mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("ignore_busy", busy, 1);
      a = 4'd1; b = 4'd1; signed_mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) cnt++;
         tick();
      end
      chk("ignore_done_count", cnt, 1);
      chk("ignore_product", product, 8'd42);

      // Reset in the second RUN cycle aborts without done.
      a = 4'd9; b = 4'd9; signed_mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_product", product, 0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) cnt++;
         tick();
      end
      chk("abort_no_done", cnt, 0);

      // Back-to-back: start held through DONE.
      a = 4'd2; b = 4'd3; signed_mode = 1'b0; start = 1'b1;
      tick();
      cnt = 0;
      while (!done && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("b2b_first_latency", cnt, 5);
      chk("b2b_first_product", product, 8'd6);
      a = 4'd5; b = 4'd5;
      tick();
      start = 1'b0;
      chk("b2b_no_idle_gap", busy, 1);
      gap = 1;
      cnt = 0;
      while (cnt < 20) begin
         tick();
         cnt++;
         if (done) break;
         gap++;
      end
      chk("b2b_second_done", done, 1);
      chk("b2b_gap", gap, 5);
      chk("b2b_second_product", product, 8'd25);
      tick();
      chk("b2b_done_pulse", done, 0);

      // Unsigned-only build ignores signed_mode.
      u_a = 4'hF; u_b = 4'h2; u_signed_mode = 1'b1; u_start = 1'b1;
      tick();
      u_start = 1'b0;
      cnt = 0;
      while (!u_done && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("unsigned_only_latency", cnt, 5);
      chk("unsigned_only_product", u_product, 8'h1E);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
